// File: rtl/rgb_led_seq_pkg.sv
// Shared types and field layout for the RGB LED step sequencer.
// Optional PWM dimming is enabled with the RGB_LED_SEQ_PWM_EN macro.
package rgb_led_seq_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  // Table entry layout: {dur, led5_rgb, led4_rgb}
  localparam int unsigned RgbW    = 3;
  localparam int unsigned LedW    = 2 * RgbW;
  localparam int unsigned Led4Lsb = 0;
  localparam int unsigned Led5Lsb = RgbW;
  localparam int unsigned DurLsb  = LedW;

  // Bit positions inside one rgb triple
  localparam int unsigned RBit = 2;
  localparam int unsigned GBit = 1;
  localparam int unsigned BBit = 0;

  localparam int unsigned PwmW = 4;

endpackage

// File: rtl/rgb_led_seq_prescaler.sv
// Divides the clock into a one-cycle tick every TICK_DIV cycles; clr restarts the period.
module rgb_led_seq_prescaler #(
  parameter int unsigned TICK_DIV = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rgb_led_sequencer.sv
// Programmable step sequencer for LED4/LED5; plays a written table once or in a loop.
// Define RGB_LED_SEQ_PWM_EN to add the duty input and PWM dimming of the LED drives.
module rgb_led_sequencer
  import rgb_led_seq_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TICK_DIV = 12,
  parameter int unsigned DUR_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef RGB_LED_SEQ_PWM_EN
  input  logic [PwmW-1:0]            duty,
`endif
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DUR_W+LedW-1:0]      wr_data,
  output logic                       wr_ready,
  input  logic [$clog2(DEPTH):0]     num_steps,
  input  logic                       loop_en,
  input  logic                       start,
  input  logic                       stop,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic                       led4_r,
  output logic                       led4_g,
  output logic                       led4_b,
  output logic                       led5_r,
  output logic                       led5_g,
  output logic                       led5_b
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = DUR_W + LedW;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW:0]       num_q, num_d;
  logic              loop_q, loop_d;
  logic [DUR_W-1:0]  tmr_q, tmr_d;
  logic [LedW-1:0]   led_q, led_d;
  logic              done_q, done_d;
  logic              presc_clr;
  logic              tick;
  logic [EW-1:0]     table_q [DEPTH];

  logic [DUR_W-1:0]  cur_dur;
  logic              last_tick;
  logic              last_step;
  logic              start_go;
  logic              pwm_on;

  rgb_led_seq_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (presc_clr),
    .tick (tick)
  );

  // Table has no reset; writes are only accepted while idle.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == StIdle)) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  assign cur_dur   = table_q[idx_q][DurLsb +: DUR_W];
  // A zero duration behaves as one tick.
  assign last_tick = tick && ((cur_dur <= DUR_W'(1)) || (tmr_q == cur_dur - DUR_W'(1)));
  assign last_step = ({1'b0, idx_q} == (num_q - (AW+1)'(1)));
  assign start_go  = start && !stop;

`ifdef RGB_LED_SEQ_PWM_EN
  logic [PwmW-1:0] pwm_q, pwm_d;

  assign pwm_d  = pwm_q + PwmW'(1);
  // Gate against the counter value that will be current once led_q updates.
  assign pwm_on = (pwm_d <= duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end
`else
  assign pwm_on = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_go && (num_steps != '0)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
        end else if (last_tick && last_step && !loop_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state and output values
  always_comb begin
    idx_d     = idx_q;
    num_d     = num_q;
    loop_d    = loop_q;
    tmr_d     = tmr_q;
    done_d    = 1'b0;
    presc_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        idx_d = '0;
        tmr_d = '0;
        if (start_go) begin
          num_d     = (num_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_steps;
          loop_d    = loop_en;
          presc_clr = 1'b1;
          done_d    = (num_steps == '0);
        end
      end
      StRun: begin
        if (stop) begin
          idx_d = '0;
          tmr_d = '0;
        end else if (last_tick) begin
          tmr_d = '0;
          if (last_step) begin
            idx_d  = '0;
            done_d = !loop_q;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end else if (tick) begin
          tmr_d = tmr_q + DUR_W'(1);
        end
      end
      default: ;
    endcase

    led_d = '0;
    if (state_d == StRun) begin
      led_d = table_q[idx_d][LedW-1:0] & {LedW{pwm_on}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      num_q  <= '0;
      loop_q <= 1'b0;
      tmr_q  <= '0;
      led_q  <= '0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      num_q  <= num_d;
      loop_q <= loop_d;
      tmr_q  <= tmr_d;
      led_q  <= led_d;
      done_q <= done_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign wr_ready = (state_q == StIdle);
  assign done     = done_q;
  assign step_idx = idx_q;

  assign led4_r = led_q[Led4Lsb + RBit];
  assign led4_g = led_q[Led4Lsb + GBit];
  assign led4_b = led_q[Led4Lsb + BBit];
  assign led5_r = led_q[Led5Lsb + RBit];
  assign led5_g = led_q[Led5Lsb + GBit];
  assign led5_b = led_q[Led5Lsb + BBit];

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Scoreboard bench for rgb_led_sequencer with TICK_DIV=4; PWM checks when RGB_LED_SEQ_PWM_EN is set.
module tb_rgb_led_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] duty;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [9:0] wr_data;
  logic       wr_ready;
  logic [3:0] num_steps;
  logic       loop_en;
  logic       start;
  logic       stop;
  logic       busy;
  logic       done;
  logic [2:0] step_idx;
  logic       led4_r, led4_g, led4_b, led5_r, led5_g, led5_b;

  typedef struct {
    string       tag;
    logic [11:0] val;
  } exp_t;

  exp_t       q[$];
  logic [9:0] sh [8];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  rgb_led_sequencer #(
    .DEPTH   (8),
    .TICK_DIV(TD),
    .DUR_W   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef RGB_LED_SEQ_PWM_EN
    .duty     (duty),
`endif
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .num_steps(num_steps),
    .loop_en  (loop_en),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx),
    .led4_r   (led4_r),
    .led4_g   (led4_g),
    .led4_b   (led4_b),
    .led5_r   (led5_r),
    .led5_g   (led5_g),
    .led5_b   (led5_b)
  );

  // {busy, done, wr_ready, step_idx, led5 rgb, led4 rgb}
  function automatic logic [11:0] obs();
    return {busy, done, wr_ready, step_idx, led5_r, led5_g, led5_b, led4_r, led4_g, led4_b};
  endfunction

  function automatic logic [11:0] ev(input bit b, input bit d, input logic [2:0] idx,
                                     input logic [5:0] leds);
    return {b, d, ~b, idx, leds};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [11:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic push_step(input string tag, input int idx);
    int d;
    d = int'(sh[idx][9:6]);
    if (d == 0) d = 1;
    repeat (d * TD) push(tag, ev(1'b1, 1'b0, 3'(idx), sh[idx][5:0]));
  endtask

  task automatic push_done(input string tag);
    push(tag, ev(1'b0, 1'b1, 3'd0, 6'd0));
    push(tag, ev(1'b0, 1'b0, 3'd0, 6'd0));
  endtask

  task automatic drain_n(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL drain_empty observed=%h expected=none", obs());
      end else begin
        e = q.pop_front();
        check(e.tag, obs(), e.val);
      end
    end
  endtask

  task automatic drain_all();
    while (q.size() > 0) drain_n(1);
  endtask

  task automatic wr(input int addr, input logic [9:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 3'(addr);
    wr_data = data;
    @(posedge clk);
    #1 wr_en = 1'b0;
    sh[addr] = data;
  endtask

  task automatic drive_start(input bit with_stop);
    @(negedge clk);
    start = 1'b1;
    stop  = with_stop;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    duty      = 4'd15;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    num_steps = '0;
    loop_en   = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", obs(), ev(1'b0, 1'b0, 3'd0, 6'd0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset", obs(), ev(1'b0, 1'b0, 3'd0, 6'd0));

    // Two-step single run
    wr(0, {4'd2, 3'b100, 3'b010});
    wr(1, {4'd1, 3'b001, 3'b001});
    num_steps = 4'd2;
    loop_en   = 1'b0;
    push_step("t1_s0", 0);
    push_step("t1_s1", 1);
    push_done("t1_end");
    drive_start(1'b0);
    drain_all();

    // Looping run, stopped two cycles into the second step1
    loop_en = 1'b1;
    push_step("t2_s0", 0);
    push_step("t2_s1", 1);
    push_step("t2_s0b", 0);
    push("t2_s1b", ev(1'b1, 1'b0, 3'd1, sh[1][5:0]));
    push("t2_s1b", ev(1'b1, 1'b0, 3'd1, sh[1][5:0]));
    drive_start(1'b0);
    drain_all();
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    push("t2_stop", ev(1'b0, 1'b0, 3'd0, 6'd0));
    push("t2_stop", ev(1'b0, 1'b0, 3'd0, 6'd0));
    drain_all();

    // Zero duration behaves as one tick; zero steps just pulses done
    loop_en = 1'b0;
    wr(0, {4'd0, 3'b110, 3'b011});
    num_steps = 4'd1;
    push_step("t3_dur0", 0);
    push_done("t3_dur0_end");
    drive_start(1'b0);
    drain_all();
    num_steps = 4'd0;
    push_done("t3_zero");
    drive_start(1'b0);
    drain_all();

    // num_steps above DEPTH is clamped to the full table
    for (int i = 0; i < 8; i++) wr(i, {4'd1, 3'(i), 3'(7 - i)});
    num_steps = 4'd9;
    for (int i = 0; i < 8; i++) push_step("t4_clamp", i);
    push_done("t4_end");
    drive_start(1'b0);
    drain_all();

    // Writes during RUN are dropped
    wr(0, {4'd2, 3'b100, 3'b010});
    wr(1, {4'd1, 3'b001, 3'b001});
    num_steps = 4'd2;
    push_step("t5_s0", 0);
    push_step("t5_s1", 1);
    push_done("t5_end");
    drive_start(1'b0);
    drain_n(2);
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = {4'd2, 3'b111, 3'b111};
    drain_n(3);
    wr_en = 1'b0;
    drain_all();
    push_step("t5_keep_s0", 0);
    push_step("t5_keep_s1", 1);
    push_done("t5_keep_end");
    drive_start(1'b0);
    drain_all();

    // Asynchronous reset mid-run, then start+stop together in IDLE
    push_step("t6_s0", 0);
    drive_start(1'b0);
    drain_n(3);
    rst_n = 1'b0;
    #1 check("t6_rst", obs(), ev(1'b0, 1'b0, 3'd0, 6'd0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_release", obs(), ev(1'b0, 1'b0, 3'd0, 6'd0));
    push("t6_startstop", ev(1'b0, 1'b0, 3'd0, 6'd0));
    push("t6_startstop", ev(1'b0, 1'b0, 3'd0, 6'd0));
    drive_start(1'b1);
    drain_all();

`ifdef RGB_LED_SEQ_PWM_EN
    begin
      int hi;
      wr(0, {4'd15, 3'b111, 3'b111});
      num_steps = 4'd1;
      duty      = 4'd3;
      drive_start(1'b0);
      hi = 0;
      repeat (16) begin
        @(negedge clk);
        if (led4_r) hi++;
      end
      checks++;
      assert (hi == 4)
      else begin
        errors++;
        $error("FAIL pwm_duty3 observed=%0d expected=4", hi);
      end
      duty = 4'd15;
      @(negedge clk);
      hi = 0;
      repeat (8) begin
        @(negedge clk);
        if (led5_b) hi++;
      end
      checks++;
      assert (hi == 8)
      else begin
        errors++;
        $error("FAIL pwm_duty15 observed=%0d expected=8", hi);
      end
      stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_led_sequencer.md
# rgb_led_sequencer

Programmable step sequencer driving the two on-board RGB LEDs (LED4, LED5). Host logic writes a small table of steps, each holding a colour for both LEDs and a duration in prescaled ticks, then pulses `start`. The block plays the table once or in a loop, replacing hard-coded blink patterns with a reusable controller that sits between control logic and the LED pins.

## Interface
- `DEPTH`, 8: step table entries (power of two, 2..16)
- `TICK_DIV`, 12: clock cycles per tick (≥2)
- `DUR_W`, 4: width of per-step duration field
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `wr_en` in 1: table write strobe
- `wr_addr` in log2(DEPTH): table index
- `wr_data` in DUR_W+6: {dur, led5_rgb[2:0], led4_rgb[2:0]}, rgb order {r,g,b}
- `wr_ready` out 1: table writable (high only in IDLE)
- `num_steps` in log2(DEPTH)+1: steps to play, sampled on start
- `loop_en` in 1: restart at step 0 after last step, sampled on start
- `start` in 1: begin playback pulse
- `stop` in 1: abort playback
- `busy` out 1: playback active
- `done` out 1: one-cycle pulse at natural end of non-looping run
- `step_idx` out log2(DEPTH): current step
- `led4_r/g/b`, `led5_r/g/b` out 1 each: registered LED drives, active-high

## Operation
- States: IDLE, RUN. No other states.
- IDLE: LEDs 0, busy 0, wr_ready 1. `wr_en` writes entry `wr_addr` at the edge; writes while wr_ready=0 are dropped.
- IDLE + start (stop low): latch num_steps (clamped to DEPTH) and loop_en; clear prescaler and step timer; step_idx←0; enter RUN.
- num_steps=0 on start: stay IDLE, pulse done, LEDs stay 0.
- RUN: LEDs show entry[step_idx]. Step lasts max(dur,1) ticks. On expiry: next step; after step num_steps−1 → step 0 if loop_en else IDLE with LEDs 0 and done pulse.
- stop in RUN: IDLE next edge, LEDs 0, no done. start+stop same cycle: stop wins.
- start during RUN ignored. Table contents persist across runs; not cleared by stop.
- Reset: state IDLE, step_idx 0, all LEDs 0, busy 0, done 0, wr_ready 1; table contents undefined (bench must write before use).

## Timing
- start sampled at edge N → at edge N+1 LEDs = entry 0, busy=1, wr_ready=0.
- Step k occupies exactly max(dur_k,1)·TICK_DIV cycles; step change visible at the edge the final tick expires.
- Natural end: LEDs 0, busy 0, done 1 on same edge; done low next cycle; new start accepted the cycle done is high.
- Write at edge N visible to a run started at edge N+1.
- Asynchronous reset mid-run forces outputs to reset values immediately.

## Configuration
- `RGB_LED_SEQ_PWM_EN`: adds input `duty` (4 bits) and a free-running 4-bit PWM counter. Each LED output = table bit AND (pwm_cnt ≤ duty); duty 15 = full on, 0 = 1/16. PWM counter reset 0, runs in all states.
- Without the macro: no `duty` port, LED outputs equal table bits directly.

## Structure
- Package `rgb_led_seq_pkg`: state enum, wr_data field offsets/widths, RGB bit positions, PWM counter width.
- Sub-module `rgb_led_seq_prescaler`: TICK_DIV counter with synchronous clear, outputs one-cycle `tick`.
- Table, step timer, FSM, output registers in top.

## Test plan
- TICK_DIV=4: write entry0 {dur 2, led5 100, led4 010}, entry1 {dur 1, 001, 001}, num_steps 2, loop_en 0, start → LED4 g on 8 cycles, then both b 4 cycles, then all 0 with done pulse, busy 0.
- Same table, loop_en 1 → pattern repeats step0,step1,step0; stop mid step1 → LEDs 0 next edge, no done.
- dur 0 entry → step lasts 4 cycles (one tick); num_steps 0 → done pulse only, busy stays 0.
- wr_en during RUN to entry0 with new colour → ignored; next run shows original colour.
- Assert rst_n low mid-run → all outputs 0 immediately, wr_ready 1 after release; start+stop same cycle in IDLE → stays IDLE.
- PWM_EN build, duty 3, entry all-on → each LED high 4 of every 16 cycles; duty 15 → continuously high.
